// File: rtl/bp_elastic_ingress.sv
// Multi-channel elastic ingress buffer: one first-word-fall-through FIFO per
// switch port, with registered ready, occupancy, sticky overflow and optional packet hold.
module bp_elastic_ingress #(
    parameter int NCH      = 4,
    parameter int A_W      = 2,
    parameter int D_W      = 32,
    parameter int DEPTH    = 4,
    parameter int PKT_MODE = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NCH*(A_W+D_W)-1:0]           s_axis_wdata,
    input  logic [NCH-1:0]                     s_axis_wvalid,
    input  logic [NCH-1:0]                     s_axis_wlast,
    output logic [NCH-1:0]                     s_axis_wready,
    output logic [NCH*(A_W+D_W)-1:0]           m_axis_wdata,
    output logic [NCH-1:0]                     m_axis_wvalid,
    output logic [NCH-1:0]                     m_axis_wlast,
    input  logic [NCH-1:0]                     m_axis_wready,
    output logic [NCH*$clog2(DEPTH+1)-1:0]     level,
    output logic [NCH-1:0]                     ovf
);

    localparam int P_W   = A_W + D_W;
    localparam int E_W   = P_W + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [E_W-1:0]   mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
        logic             rdy_en;
        logic             ovf_q;
        logic             wready;
        logic             wvalid_m;
        logic             push;
        logic             pop;
        logic [E_W-1:0]   head;
        logic             head_last;

        // Ready depends only on flops, so downstream backpressure never reaches upstream combinationally.
        assign wready    = rdy_en & (count != CNT_FULL);
        assign push      = s_axis_wvalid[c] & wready;
        assign pop       = wvalid_m & m_axis_wready[c];
        assign head      = mem[rd_ptr];
        assign head_last = head[E_W-1];

        // NOTE: the storage array has no reset; stale entries are never visible because
        // valid is derived from the reset count, and leaving it unreset keeps it a plain RAM.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= {s_axis_wlast[c], s_axis_wdata[c*P_W +: P_W]};
            end
        end

        // NOTE: every state flop here uses non-blocking assignment so all updates
        // see the pre-edge values of push/pop/count.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                rdy_en <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                rdy_en <= 1'b1;
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
                ovf_q <= ovf_q | (s_axis_wvalid[c] & ~rdy_en) | (count > CNT_FULL);
            end
        end

        if (PKT_MODE != 0) begin : g_pkt
            logic [CNT_W-1:0] pkt_cnt;
            logic             pkt_in;
            logic             pkt_out;

            assign pkt_in  = push & s_axis_wlast[c];
            assign pkt_out = pop & head_last;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pkt_cnt <= '0;
                end else begin
                    pkt_cnt <= pkt_cnt + CNT_W'(pkt_in) - CNT_W'(pkt_out);
                end
            end

            // A full FIFO with no complete packet releases words anyway; otherwise it would deadlock.
            assign wvalid_m = (count != CNT_ZERO) & ((pkt_cnt != CNT_ZERO) | (count == CNT_FULL));
        end else begin : g_ct
            assign wvalid_m = (count != CNT_ZERO);
        end

        assign s_axis_wready[c]            = wready;
        assign m_axis_wvalid[c]            = wvalid_m;
        assign m_axis_wdata[c*P_W +: P_W]  = head[P_W-1:0];
        assign m_axis_wlast[c]             = head_last;
        assign level[c*CNT_W +: CNT_W]     = count;
        assign ovf[c]                      = ovf_q;
    end

endmodule

// File: tb/tb_bp_elastic_ingress.sv
// Directed bench for bp_elastic_ingress: one cut-through and one packet-mode
// instance, driven from a vector table plus hand sequences for stall and reset cases.
module tb_bp_elastic_ingress;

    localparam int NCH = 4;
    localparam int P_W = 34;
    localparam int L_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [NCH*P_W-1:0] s_data0 = '0, s_data1 = '0;
    logic [NCH-1:0]     s_valid0 = '0, s_valid1 = '0;
    logic [NCH-1:0]     s_last0 = '0, s_last1 = '0;
    logic [NCH-1:0]     m_ready0 = '1, m_ready1 = '1;
    logic [NCH-1:0]     s_ready0, s_ready1;
    logic [NCH*P_W-1:0] m_data0, m_data1;
    logic [NCH-1:0]     m_valid0, m_valid1;
    logic [NCH-1:0]     m_last0, m_last1;
    logic [NCH*L_W-1:0] level0, level1;
    logic [NCH-1:0]     ovf0, ovf1;

    int total = 0;
    int bad   = 0;

    bp_elastic_ingress #(.NCH(4), .A_W(2), .D_W(32), .DEPTH(4), .PKT_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_wdata(s_data0), .s_axis_wvalid(s_valid0), .s_axis_wlast(s_last0),
        .s_axis_wready(s_ready0),
        .m_axis_wdata(m_data0), .m_axis_wvalid(m_valid0), .m_axis_wlast(m_last0),
        .m_axis_wready(m_ready0),
        .level(level0), .ovf(ovf0)
    );

    bp_elastic_ingress #(.NCH(4), .A_W(2), .D_W(32), .DEPTH(4), .PKT_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_wdata(s_data1), .s_axis_wvalid(s_valid1), .s_axis_wlast(s_last1),
        .s_axis_wready(s_ready1),
        .m_axis_wdata(m_data1), .m_axis_wvalid(m_valid1), .m_axis_wlast(m_last1),
        .m_axis_wready(m_ready1),
        .level(level1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dut;
        int          ch;
        bit          v;
        logic [33:0] d;
        bit          l;
        bit          mr;
        bit          ev;
        logic [33:0] ed;
        bit          el;
        int          elev;
        bit          er;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit dut, int ch, bit v, logic [33:0] d, bit l, bit mr,
                                bit ev, logic [33:0] ed, bit el, int elev, bit er);
        vec_t r;
        r.dut = dut; r.ch = ch; r.v = v; r.d = d; r.l = l; r.mr = mr;
        r.ev = ev; r.ed = ed; r.el = el; r.elev = elev; r.er = er;
        return r;
    endfunction

    // Drive one record at the falling edge and compare the pre-edge outputs.
    task automatic apply(input int i);
        vec_t        r;
        logic        mv, ml, sr;
        logic [33:0] md;
        logic [2:0]  lv;
        r = tbl[i];
        @(negedge clk);
        s_valid0 = '0; s_valid1 = '0; s_last0 = '0; s_last1 = '0;
        m_ready0 = '1; m_ready1 = '1;
        if (r.dut == 1'b0) begin
            s_valid0[r.ch] = r.v; s_last0[r.ch] = r.l; m_ready0[r.ch] = r.mr;
            s_data0[r.ch*P_W +: P_W] = r.d;
            mv = m_valid0[r.ch]; ml = m_last0[r.ch]; sr = s_ready0[r.ch];
            md = m_data0[r.ch*P_W +: P_W]; lv = level0[r.ch*L_W +: L_W];
        end else begin
            s_valid1[r.ch] = r.v; s_last1[r.ch] = r.l; m_ready1[r.ch] = r.mr;
            s_data1[r.ch*P_W +: P_W] = r.d;
            mv = m_valid1[r.ch]; ml = m_last1[r.ch]; sr = s_ready1[r.ch];
            md = m_data1[r.ch*P_W +: P_W]; lv = level1[r.ch*L_W +: L_W];
        end
        check($sformatf("v%0d_valid", i), 64'(mv), 64'(r.ev));
        check($sformatf("v%0d_level", i), 64'(lv), 64'(r.elev));
        check($sformatf("v%0d_ready", i), 64'(sr), 64'(r.er));
        if (r.ev) begin
            check($sformatf("v%0d_data", i), 64'(md), 64'(r.ed));
            check($sformatf("v%0d_last", i), 64'(ml), 64'(r.el));
        end
    endtask

    int          w;
    logic        acc;
    logic [33:0] got[$];

    // One cycle of the ch2 stall sequence on the cut-through instance.
    task automatic cyc2();
        @(negedge clk);
        s_valid0 = '0; s_last0 = '0;
        s_valid0[2] = (w <= 6);
        s_data0[2*P_W +: P_W] = 34'(w);
        acc = s_valid0[2] & s_ready0[2];
        if (m_valid0[2] & m_ready0[2]) got.push_back(m_data0[2*P_W +: P_W]);
        @(posedge clk);
        #1;
        if (acc) w++;
    endtask

    initial begin
        // streaming, cut-through, ch0: rows 0..9
        tbl.push_back(mk(0, 0, 1, 34'h11, 0, 1, 0, 34'h0,  0, 0, 1));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk(0, 0, 1, 34'(8'h11 + k), (k == 7), 1, 1, 34'(8'h11 + k - 1), 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 34'h0,  0, 1, 1, 34'h18, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 34'h0,  0, 1, 0, 34'h0,  0, 0, 1));
        // packet mode, ch1: full packet then no-wlast fallback, rows 10..27
        tbl.push_back(mk(1, 1, 1, 34'h21, 0, 1, 0, 34'h0,  0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 34'h22, 0, 1, 0, 34'h0,  0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 34'h23, 1, 1, 0, 34'h0,  0, 2, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h21, 0, 3, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h22, 0, 2, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h23, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 0, 34'h0,  0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 34'h31, 0, 1, 0, 34'h0,  0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 34'h32, 0, 1, 0, 34'h0,  0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 34'h33, 0, 1, 0, 34'h0,  0, 2, 1));
        tbl.push_back(mk(1, 1, 1, 34'h34, 0, 1, 0, 34'h0,  0, 3, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h31, 0, 4, 0));
        tbl.push_back(mk(1, 1, 1, 34'h35, 1, 1, 0, 34'h0,  0, 3, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h32, 0, 4, 0));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h33, 0, 3, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h34, 0, 2, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h35, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 0, 34'h0,  0, 0, 1));
        // simultaneous push/pop at count=3, cut-through ch3: rows 28..36
        tbl.push_back(mk(0, 3, 1, 34'h41, 0, 0, 0, 34'h0,  0, 0, 1));
        tbl.push_back(mk(0, 3, 1, 34'h42, 0, 0, 1, 34'h41, 0, 1, 1));
        tbl.push_back(mk(0, 3, 1, 34'h43, 0, 0, 1, 34'h41, 0, 2, 1));
        tbl.push_back(mk(0, 3, 1, 34'h44, 0, 1, 1, 34'h41, 0, 3, 1));
        tbl.push_back(mk(0, 3, 1, 34'h45, 0, 1, 1, 34'h42, 0, 3, 1));
        tbl.push_back(mk(0, 3, 0, 34'h0,  0, 1, 1, 34'h43, 0, 3, 1));
        tbl.push_back(mk(0, 3, 0, 34'h0,  0, 1, 1, 34'h44, 0, 2, 1));
        tbl.push_back(mk(0, 3, 0, 34'h0,  0, 1, 1, 34'h45, 0, 1, 1));
        tbl.push_back(mk(0, 3, 0, 34'h0,  0, 1, 0, 34'h0,  0, 0, 1));
        // packet after mid-packet reset, packet-mode ch1: rows 37..41
        tbl.push_back(mk(1, 1, 1, 34'h71, 0, 1, 0, 34'h0,  0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 34'h72, 1, 1, 0, 34'h0,  0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h71, 0, 2, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 1, 34'h72, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 34'h0,  0, 1, 0, 34'h0,  0, 0, 1));

        // reset and ready release
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_ready0", 64'(s_ready0), 64'h0);
            check("rst_ready1", 64'(s_ready1), 64'h0);
            check("rst_valid0", 64'(m_valid0), 64'h0);
            check("rst_level0", 64'(level0), 64'h0);
            check("rst_ovf0",   64'(ovf0),   64'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_ready_pre", 64'(s_ready0), 64'h0);
        @(posedge clk);
        #1;
        check("rel_ready0", 64'(s_ready0), 64'hF);
        check("rel_ready1", 64'(s_ready1), 64'hF);
        check("rel_valid1", 64'(m_valid1), 64'h0);
        check("rel_level1", 64'(level1), 64'h0);

        for (int i = 0; i <= 36; i++) apply(i);

        // ch2 full stall on the cut-through instance
        @(negedge clk);
        s_valid0 = '0; s_valid1 = '0; m_ready1 = '1;
        m_ready0 = 4'b1011;
        w = 1;
        got.delete();
        repeat (6) cyc2();
        check("stall_level2",  64'(level0[2*L_W +: L_W]), 64'd4);
        check("stall_ready2",  64'(s_ready0[2]), 64'h0);
        check("stall_accept",  64'(w), 64'd5);
        check("stall_ready0",  64'(s_ready0[0]), 64'h1);
        check("stall_level0",  64'(level0[0 +: L_W]), 64'd0);
        check("stall_popped",  64'(got.size()), 64'd0);
        m_ready0 = 4'hF;
        cyc2();
        check("bubble_accept", 64'(w), 64'd5);
        check("bubble_ready2", 64'(s_ready0[2]), 64'h1);
        repeat (8) cyc2();
        check("drain_count", 64'(got.size()), 64'd6);
        for (int k = 0; k < 6 && k < got.size(); k++)
            check($sformatf("drain_word%0d", k), 64'(got[k]), 64'(k + 1));
        check("drain_accept", 64'(w), 64'd7);
        check("drain_level2", 64'(level0[2*L_W +: L_W]), 64'd0);
        check("drain_ovf0",   64'(ovf0), 64'h0);

        // asynchronous reset with words buffered
        m_ready0 = '0; m_ready1 = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_valid0 = 4'b0001; s_data0[0 +: P_W] = 34'(8'h60 + k);
            s_valid1 = 4'b0010; s_data1[P_W +: P_W] = 34'(8'h61 + k);
            s_last1  = (k == 1) ? 4'b0010 : 4'b0000;
        end
        @(negedge clk);
        s_valid0 = '0; s_valid1 = '0; s_last1 = '0;
        check("pre_rst_valid0", 64'(m_valid0[0]), 64'h1);
        check("pre_rst_valid1", 64'(m_valid1[1]), 64'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid0", 64'(m_valid0), 64'h0);
        check("arst_valid1", 64'(m_valid1), 64'h0);
        check("arst_ready0", 64'(s_ready0), 64'h0);
        check("arst_ready1", 64'(s_ready1), 64'h0);
        check("arst_level1", 64'(level1), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        m_ready0 = '1; m_ready1 = '1;
        for (int i = 37; i <= 41; i++) apply(i);

        // write presented before ready comes up sets the sticky flag
        @(negedge clk);
        s_valid0 = '0; s_valid1 = '0;
        rst = 1'b0;
        @(negedge clk);
        s_valid0 = 4'b0001;
        rst = 1'b1;
        @(posedge clk);
        #1;
        s_valid0 = '0;
        check("ovf_set0",  64'(ovf0), 64'h1);
        check("ovf_other", 64'(ovf1), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_sticky", 64'(ovf0), 64'h1);
        check("ovf_level0", 64'(level0), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
